exe_muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer that sits beside the single-cycle execute ALU.
- Handles mult, multu, div and divu using an iterative shift-add / restoring-subtract datapath, and owns the HI/LO registers.
- Raises busy so the fetch/decode control stalls the CPU until the result is written.
- Operands come from the decoder's rs/rt read ports (Read_data_1, Read_data_2).

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_sign_fix.sv | 16 +
 rtl/exe_muldiv_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_exe_muldiv_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  // Iterations per operation; one result bit per CALC cycle.
  localparam int unsigned ITER = WIDTH_DEF;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction at operand
// capture and sign restoration of the product/quotient/remainder.
module muldiv_sign_fix #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] val_i,
  input  logic             neg_i,
  output logic [Width-1:0] res_o
);

  // Negate when requested, otherwise pass through.
  always_comb begin
    res_o = neg_i ? (~val_i + Width'(1)) : val_i;
  end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO.
// Shift-add multiply and restoring divide on unsigned magnitudes, signs fixed
// up in FIX. Optional macro MULDIV_EARLY_TERM_EN lets mult/multu leave CALC
// once the remaining multiplier bits are all zero.
module exe_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = ITER,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Read_data_1,
  input  logic [WIDTH-1:0] Read_data_2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned W2 = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [W2-1:0]     acc_q, acc_d;     // {remainder, quotient} or {product hi, product lo/multiplier}
  logic [WIDTH-1:0]  b_q, b_d;         // multiplicand or divisor magnitude
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              dbz_q, dbz_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  // Operand capture decode
  logic             cap_signed, cap_div;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign cap_signed = (op == OP_MULT) || (op == OP_DIV);
  assign cap_div    = (op == OP_DIV) || (op == OP_DIVU);

  muldiv_sign_fix #(.Width(WIDTH)) u_mag_a (
    .val_i (Read_data_1),
    .neg_i (cap_signed & Read_data_1[WIDTH-1]),
    .res_o (mag_a)
  );

  muldiv_sign_fix #(.Width(WIDTH)) u_mag_b (
    .val_i (Read_data_2),
    .neg_i (cap_signed & Read_data_2[WIDTH-1]),
    .res_o (mag_b)
  );

  // Sign restoration of the finished magnitudes
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  muldiv_sign_fix #(.Width(W2)) u_fix_prod (
    .val_i (acc_q),
    .neg_i (neg_lo_q),
    .res_o (prod_fix)
  );

  muldiv_sign_fix #(.Width(WIDTH)) u_fix_quo (
    .val_i (acc_q[WIDTH-1:0]),
    .neg_i (neg_lo_q),
    .res_o (quo_fix)
  );

  muldiv_sign_fix #(.Width(WIDTH)) u_fix_rem (
    .val_i (acc_q[W2-1:WIDTH]),
    .neg_i (neg_hi_q),
    .res_o (rem_fix)
  );

  // One iteration of shift-add multiply and restoring divide
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_acc;
  logic [WIDTH:0]  rem_sh, div_diff;
  logic [W2-1:0]   div_acc;

  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_acc  = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, b_q};
    // A borrow means the trial subtraction failed: keep the shifted remainder.
    div_acc  = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

`ifdef MULDIV_EARLY_TERM_EN
  // Unconsumed multiplier bits sit at acc_q[cnt_q:1] during a CALC cycle.
  logic mul_rest_zero;

  always_comb begin
    mul_rest_zero = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      if ((i <= 32'(cnt_q)) && acc_q[i]) mul_rest_zero = 1'b0;
    end
  end
`endif

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (flush) begin
      state_d = IDLE;
      dbz_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            is_div_d = cap_div;
            cnt_d    = CNT_W'(WIDTH - 1);
            neg_lo_d = cap_signed & (Read_data_1[WIDTH-1] ^ Read_data_2[WIDTH-1]);
            neg_hi_d = cap_div ? (cap_signed & Read_data_1[WIDTH-1])
                               : (cap_signed & (Read_data_1[WIDTH-1] ^ Read_data_2[WIDTH-1]));
            if (cap_div) begin
              acc_d = {{WIDTH{1'b0}}, mag_a};
              b_d   = mag_b;
            end else begin
              acc_d = {{WIDTH{1'b0}}, mag_b};
              b_d   = mag_a;
            end
            if (cap_div && (Read_data_2 == '0)) begin
              dbz_d   = 1'b1;
              state_d = DONE;
            end else begin
              dbz_d   = 1'b0;
              state_d = CALC;
            end
          end else begin
            if (mthi) hi_d = Read_data_1;
            if (mtlo) lo_d = Read_data_1;
          end
        end
        CALC: begin
          cnt_d = cnt_q - CNT_W'(1);
          acc_d = is_div_q ? div_acc : mul_acc;
          if (cnt_q == '0) state_d = FIX;
`ifdef MULDIV_EARLY_TERM_EN
          // Remaining iterations would only shift; do them all at once.
          if (!is_div_q && mul_rest_zero) begin
            acc_d   = mul_acc >> cnt_q;
            state_d = FIX;
          end
`endif
        end
        FIX: begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          state_d = DONE;
        end
        DONE: begin
          dbz_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Status outputs decoded from state
  always_comb begin
    busy        = (state_q == CALC) || (state_q == FIX);
    done        = (state_q == DONE) && !flush;
    div_by_zero = done && dbz_q;
    HI          = hi_q;
    LO          = lo_q;
  end

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Bench for exe_muldiv_ctrl: vector table plus hand-written corner sequences.
// Busy-length expectations follow MULDIV_EARLY_TERM_EN when it is defined.
module tb_exe_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] Read_data_1 = '0;
  logic [W-1:0] Read_data_2 = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic         flush = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] HI, LO;

  exe_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .Read_data_1 (Read_data_1),
    .Read_data_2 (Read_data_2),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           busy_len;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Busy length the unit should show for an operation.
  function automatic int exp_busy(input logic [1:0] o, input logic [W-1:0] b);
    if (o[1] && (b == '0)) return 0;
`ifdef MULDIV_EARLY_TERM_EN
    if (!o[1]) begin
      logic [W-1:0] m;
      int           k;
      m = ((o == OP_MULT) && b[W-1]) ? -b : b;
      k = 0;
      for (int i = 0; i < int'(W); i++) if (m[i]) k = i;
      return k + 2;
    end
`endif
    return W + 1;
  endfunction

  // Issue one operation at the current negedge (unit must be IDLE) and
  // check it against the scoreboard when done appears. With mv set, mtlo
  // accompanies start and mthi/start are held high while busy.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz,
                        input bit mv, input string tag);
    exp_t e;
    int   bc;
    int   guard;
    e.hi = hi;
    e.lo = lo;
    e.dbz = dbz;
    e.busy_len = exp_busy(o, b);
    sb_q.push_back(e);
    op = o;
    Read_data_1 = a;
    Read_data_2 = b;
    start = 1'b1;
    mtlo = mv;
    @(negedge clock);
    start = 1'b0;
    mtlo = 1'b0;
    Read_data_1 = $urandom;
    Read_data_2 = $urandom;
    bc = 0;
    guard = 0;
    while (!done && guard < 100) begin
      if (busy) bc++;
      mthi = mv;
      start = mv;
      @(negedge clock);
      guard++;
    end
    mthi = 1'b0;
    start = 1'b0;
    e = sb_q.pop_front();
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, expected done within 100 cycles", tag);
    end else begin
      check({tag, "_busy_len"}, 64'(bc), 64'(e.busy_len));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      check({tag, "_hi"}, 64'(HI), 64'(e.hi));
      check({tag, "_lo"}, 64'(LO), 64'(e.lo));
      check({tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
    end
    @(negedge clock);
    check({tag, "_done_one_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    vecs.push_back('{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD});
    vecs.push_back('{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
    vecs.push_back('{OP_MULT,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 32'h1234_5678});
    vecs.push_back('{OP_MULT,  32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF});

    // Reset state
    repeat (2) @(negedge clock);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, 1'b0,
             $sformatf("vec%0d", i));
    end

    // mthi+mtlo together, then separately
    Read_data_1 = 32'h0000_ABCD;
    mthi = 1'b1;
    mtlo = 1'b1;
    @(negedge clock);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mv_both_hi", 64'(HI), 64'h0000_ABCD);
    check("mv_both_lo", 64'(LO), 64'h0000_ABCD);
    Read_data_1 = 32'h0000_1234;
    mthi = 1'b1;
    @(negedge clock);
    mthi = 1'b0;
    Read_data_1 = 32'h0000_5678;
    mtlo = 1'b1;
    @(negedge clock);
    mtlo = 1'b0;
    check("mthi_hi", 64'(HI), 64'h0000_1234);
    check("mtlo_lo", 64'(LO), 64'h0000_5678);

    // Divide by zero leaves HI/LO untouched
    run_op(OP_DIVU, 32'h0000_0055, 32'h0, 32'h0000_1234, 32'h0000_5678, 1'b1, 1'b0, "divu_zero");
    run_op(OP_DIV, 32'hFFFF_FF00, 32'h0, 32'h0000_1234, 32'h0000_5678, 1'b1, 1'b0, "div_zero");
    // start+mtlo: the move is dropped, so LO survives a zero divide
    run_op(OP_DIVU, 32'h0000_DEAD, 32'h0, 32'h0000_1234, 32'h0000_5678, 1'b1, 1'b1, "mv_drop_dz");

    // Flush in CALC cycle 10
    op = OP_MULT;
    Read_data_1 = 32'h0000_0003;
    Read_data_2 = 32'h4000_0000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_hi", 64'(HI), 64'h0000_1234);
    check("flush_lo", 64'(LO), 64'h0000_5678);
    run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, "after_flush");

    // start+mtlo, then mthi and start during busy: all ignored
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b1,
           "mv_ignored");

    // Asynchronous reset mid-operation
    op = OP_MULTU;
    Read_data_1 = 32'd9;
    Read_data_2 = 32'h8000_0001;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hi", 64'(HI), 64'd0);
    check("midreset_lo", 64'(LO), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("midreset_done", 64'(done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
